// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared FSM states, default constants and saturating add for the LIF engine
package lif_pkg;

  localparam int unsigned DEF_N_PRE         = 10;
  localparam int unsigned DEF_N_POST        = 10;
  localparam int unsigned DEF_MP_W          = 16;
  localparam int unsigned DEF_W_W           = 8;
  localparam int unsigned DEF_PRE_INPUT     = 1;
  localparam int unsigned DEF_PRE_THRESHOLD = 4;
  localparam int unsigned DEF_THRESHOLD     = 32;
  localparam int unsigned DEF_LEAK_SHIFT    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_ACC  = 2'd2,
    ST_FIRE = 2'd3
  } lif_state_e;

  // Unsigned add clamped to the largest value representable in 'width' bits (width <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    sat_add = (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_post_neuron.sv
// rtl/lif_post_neuron.sv - next-state logic (leak, accumulate, fire) for one postsynaptic neuron
module lif_post_neuron
  import lif_pkg::*;
#(
  parameter int unsigned MP_W       = DEF_MP_W,
  parameter int unsigned W_W        = DEF_W_W,
  parameter int unsigned THRESHOLD  = DEF_THRESHOLD,
  parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic            leak_en_i,
  input  logic            acc_en_i,
  input  logic            fire_en_i,
  input  logic [MP_W-1:0] mp_i,
  input  logic [W_W-1:0]  weight_i,
  input  logic            pre_spike_i,
  output logic [MP_W-1:0] mp_o,
  output logic            spike_o
);

  // At most one phase enable is active; the potential holds otherwise.
  always_comb begin
    mp_o    = mp_i;
    spike_o = 1'b0;
    if (leak_en_i) begin
      if (LEAK_SHIFT != 0) begin
        mp_o = mp_i - (mp_i >> LEAK_SHIFT);
      end
    end else if (acc_en_i) begin
      if (pre_spike_i) begin
        mp_o = MP_W'(sat_add(32'(mp_i), 32'(weight_i), MP_W));
      end
    end else if (fire_en_i) begin
      if (32'(mp_i) >= THRESHOLD) begin
        spike_o = 1'b1;
        mp_o    = '0;
      end
    end
  end

endmodule

// File: rtl/neuromorphic_design.sv
// rtl/neuromorphic_design.sv - single-layer LIF tick engine with fully connected synapse array
module neuromorphic_design
  import lif_pkg::*;
#(
  parameter int unsigned N_PRE         = DEF_N_PRE,
  parameter int unsigned N_POST        = DEF_N_POST,
  parameter int unsigned MP_W          = DEF_MP_W,
  parameter int unsigned W_W           = DEF_W_W,
  parameter int unsigned PRE_INPUT     = DEF_PRE_INPUT,
  parameter int unsigned PRE_THRESHOLD = DEF_PRE_THRESHOLD,
  parameter int unsigned THRESHOLD     = DEF_THRESHOLD,
  parameter int unsigned LEAK_SHIFT    = DEF_LEAK_SHIFT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              membrane_potential_syn_start,
  output logic [N_POST-1:0] spike_o,
  output logic              tick_done_o
);

  localparam int unsigned K_W = (N_PRE > 1) ? $clog2(N_PRE) : 1;

  lif_state_e        state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [N_PRE-1:0]  pre_spike_q, pre_spike_d;
  logic [N_POST-1:0] spike_q, spike_d;
  logic              tick_done_q, tick_done_d;
  logic [N_POST-1:0] fire_vec;
  logic              leak_en, acc_en, fire_en;

  logic [MP_W-1:0] presyn_membrane_potential  [N_PRE];
  logic [MP_W-1:0] pre_mp_d                   [N_PRE];
  logic [MP_W-1:0] postsyn_membrane_potential [N_POST];
  logic [MP_W-1:0] post_mp_d                  [N_POST];
  logic [W_W-1:0]  weight_static              [N_PRE][N_POST];

  assign leak_en     = (state_q == ST_PRE);
  assign acc_en      = (state_q == ST_ACC);
  assign fire_en     = (state_q == ST_FIRE);
  assign spike_o     = spike_q;
  assign tick_done_o = tick_done_q;

  // Tick sequencer: PRE once, ACC walks k over every presynaptic row, FIRE once.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    spike_d     = spike_q;
    tick_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (membrane_potential_syn_start) state_d = ST_PRE;
      end
      ST_PRE: begin
        state_d = ST_ACC;
        k_d     = '0;
      end
      ST_ACC: begin
        if (k_q == K_W'(N_PRE - 1)) begin
          state_d = ST_FIRE;
          k_d     = '0;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      ST_FIRE: begin
        spike_d     = fire_vec;
        tick_done_d = 1'b1;
        state_d     = membrane_potential_syn_start ? ST_PRE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Presynaptic neurons integrate the constant drive and fire/reset at threshold during PRE.
  always_comb begin
    pre_mp_d    = presyn_membrane_potential;
    pre_spike_d = pre_spike_q;
    if (state_q == ST_PRE) begin
      for (int i = 0; i < N_PRE; i++) begin
        if (32'(presyn_membrane_potential[i]) + PRE_INPUT >= PRE_THRESHOLD) begin
          pre_spike_d[i] = 1'b1;
          pre_mp_d[i]    = '0;
        end else begin
          pre_spike_d[i] = 1'b0;
          pre_mp_d[i]    = presyn_membrane_potential[i] + MP_W'(PRE_INPUT);
        end
      end
    end
  end

  for (genvar j = 0; j < N_POST; j++) begin : g_post
    lif_post_neuron #(
      .MP_W      (MP_W),
      .W_W       (W_W),
      .THRESHOLD (THRESHOLD),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_neuron (
      .leak_en_i  (leak_en),
      .acc_en_i   (acc_en),
      .fire_en_i  (fire_en),
      .mp_i       (postsyn_membrane_potential[j]),
      .weight_i   (weight_static[k_q][j]),
      .pre_spike_i(pre_spike_q[k_q]),
      .mp_o       (post_mp_d[j]),
      .spike_o    (fire_vec[j])
    );
  end

  // Control, neuron state and output registers; reset clears everything at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      pre_spike_q <= '0;
      spike_q     <= '0;
      tick_done_q <= 1'b0;
      for (int i = 0; i < N_PRE; i++) presyn_membrane_potential[i] <= '0;
      for (int j = 0; j < N_POST; j++) postsyn_membrane_potential[j] <= '0;
    end else begin
      state_q                    <= state_d;
      k_q                        <= k_d;
      pre_spike_q                <= pre_spike_d;
      spike_q                    <= spike_d;
      tick_done_q                <= tick_done_d;
      presyn_membrane_potential  <= pre_mp_d;
      postsyn_membrane_potential <= post_mp_d;
    end
  end

  // Weights are only cleared by reset; otherwise they hold whatever was deposited.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < N_PRE; i++) begin
        for (int j = 0; j < N_POST; j++) weight_static[i][j] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_neuromorphic_design.sv
// tb/tb_neuromorphic_design.sv - self-checking bench for neuromorphic_design against a tick-level model
module tb_neuromorphic_design;

  localparam int NPRE  = 10;
  localparam int NPOST = 10;
  localparam int MPMAX = 65535;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [NPOST-1:0] spk0, spk1;
  logic td0, td1;

  always #5 clk = ~clk;

  neuromorphic_design dut (
    .clk_i(clk), .rst_i(rst_n), .membrane_potential_syn_start(start),
    .spike_o(spk0), .tick_done_o(td0)
  );

  neuromorphic_design #(.THRESHOLD(65535), .LEAK_SHIFT(0)) dut2 (
    .clk_i(clk), .rst_i(rst_n), .membrane_potential_syn_start(start),
    .spike_o(spk1), .tick_done_o(td1)
  );

  int total = 0;
  int bad = 0;

  int mpre [2][NPRE];
  int mpost[2][NPOST];
  int mw   [2][NPRE][NPOST];
  bit mspk [2][NPOST];
  int thr  [2] = '{32, 65535};
  int ls   [2] = '{4, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NPRE; i++) begin
        mpre[d][i] = 0;
        for (int j = 0; j < NPOST; j++) mw[d][i][j] = 0;
      end
      for (int j = 0; j < NPOST; j++) begin
        mpost[d][j] = 0;
        mspk[d][j]  = 1'b0;
      end
    end
  endtask

  task automatic model_tick(input int d);
    bit ps[NPRE];
    int sum;
    for (int i = 0; i < NPRE; i++) begin
      mpre[d][i] = mpre[d][i] + 1;
      ps[i] = (mpre[d][i] >= 4);
      if (ps[i]) mpre[d][i] = 0;
    end
    for (int j = 0; j < NPOST; j++) begin
      if (ls[d] > 0) mpost[d][j] = mpost[d][j] - (mpost[d][j] >> ls[d]);
      sum = 0;
      for (int i = 0; i < NPRE; i++) if (ps[i]) sum += mw[d][i][j];
      mpost[d][j] = (mpost[d][j] + sum > MPMAX) ? MPMAX : mpost[d][j] + sum;
      mspk[d][j] = (mpost[d][j] >= thr[d]);
      if (mspk[d][j]) mpost[d][j] = 0;
    end
  endtask

  task automatic set_w0(input int i, input int j, input int v);
    dut.weight_static[i][j] = 8'(v);
    mw[0][i][j] = v;
  endtask

  task automatic set_w1(input int i, input int j, input int v);
    dut2.weight_static[i][j] = 8'(v);
    mw[1][i][j] = v;
  endtask

  task automatic compare_all(input string ph);
    for (int j = 0; j < NPOST; j++) begin
      check($sformatf("%s spike0[%0d]", ph, j), 32'(spk0[j]), 32'(mspk[0][j]));
      check($sformatf("%s spike1[%0d]", ph, j), 32'(spk1[j]), 32'(mspk[1][j]));
      check($sformatf("%s post0[%0d]", ph, j), 32'(dut.postsyn_membrane_potential[j]), 32'(mpost[0][j]));
      check($sformatf("%s post1[%0d]", ph, j), 32'(dut2.postsyn_membrane_potential[j]), 32'(mpost[1][j]));
    end
    for (int i = 0; i < NPRE; i++) begin
      check($sformatf("%s pre0[%0d]", ph, i), 32'(dut.presyn_membrane_potential[i]), 32'(mpre[0][i]));
      check($sformatf("%s pre1[%0d]", ph, i), 32'(dut2.presyn_membrane_potential[i]), 32'(mpre[1][i]));
    end
  endtask

  // Waits (bounded) for tick_done, checks its timing, advances the model and compares all state.
  task automatic run_tick(input string ph, input bit chk_period);
    bit ok;
    int cyc;
    ok = 1'b0;
    cyc = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      cyc++;
      if (td0 === 1'b1) ok = 1'b1;
    end
    check({ph, " tick_done_seen"}, 32'(ok), 32'd1);
    check({ph, " tick_done2"}, 32'(td1), 32'd1);
    if (chk_period) check({ph, " period"}, 32'(cyc), 32'd12);
    model_tick(0);
    model_tick(1);
    compare_all(ph);
  endtask

  int pre_seq[4] = '{1, 2, 3, 0};
  int cnt;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst tick_done0", 32'(td0), 32'd0);
    check("rst tick_done1", 32'(td1), 32'd0);
    check("rst weight", 32'(dut.weight_static[2][7]), 32'd0);
    compare_all("rst");

    // dut weights stay zero, dut2 saturates with all-255 weights
    for (int i = 0; i < NPRE; i++)
      for (int j = 0; j < NPOST; j++) set_w1(i, j, 255);
    start = 1'b1;
    run_tick("zero_w", 1'b0);
    check("zero_w pre_seq", 32'(dut.presyn_membrane_potential[0]), 32'(pre_seq[0]));
    @(negedge clk);
    check("tick_done width", 32'(td0), 32'd0);
    cnt = 0;
    for (int n = 0; n < 40 && cnt == 0; n++) begin
      @(negedge clk);
      if (td0 === 1'b1) cnt = 1;
    end
    check("zero_w second tick", 32'(cnt), 32'd1);
    model_tick(0);
    model_tick(1);
    compare_all("zero_w t2");
    check("zero_w pre_seq t2", 32'(dut.presyn_membrane_potential[3]), 32'(pre_seq[1]));
    for (int t = 2; t < 4; t++) begin
      run_tick("zero_w", 1'b1);
      check("zero_w pre_seq", 32'(dut.presyn_membrane_potential[5]), 32'(pre_seq[t]));
      check("zero_w post", 32'(dut.postsyn_membrane_potential[9]), 32'd0);
    end

    // random weights, re-drawn every 10 ticks; dut2 keeps integrating toward saturation
    for (int t = 0; t < 110; t++) begin
      if (t % 10 == 0) begin
        for (int i = 0; i < NPRE; i++)
          for (int j = 0; j < NPOST; j++)
            set_w0(i, j, ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 15)));
      end
      run_tick("rand", 1'b1);
    end

    // drop start mid-ACC: tick completes once, then everything freezes
    repeat (4) @(negedge clk);
    start = 1'b0;
    run_tick("stop", 1'b0);
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (td0 === 1'b1) cnt++;
    end
    check("stop idle pulses", 32'(cnt), 32'd0);
    compare_all("frozen");

    // restart, then reset mid-tick
    start = 1'b1;
    run_tick("restart", 1'b0);
    run_tick("restart", 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("midrst");
    check("midrst tick_done", 32'(td0), 32'd0);
    check("midrst weight0", 32'(dut.weight_static[4][4]), 32'd0);
    check("midrst weight1", 32'(dut2.weight_static[0][9]), 32'd0);
    cnt = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (td0 === 1'b1 || td1 === 1'b1) cnt++;
    end
    check("midrst pulses", 32'(cnt), 32'd0);

    // after reset: row 0 weights of 20 exercise the leak path
    for (int j = 0; j < NPOST; j++) set_w0(0, j, 20);
    rst_n = 1'b1;
    run_tick("leak", 1'b0);
    for (int t = 1; t < 9; t++) run_tick("leak", 1'b1);

    start = 1'b0;
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
